wen_decoder_pipe: RTL
=====================

// Module: wen_decoder_pipe
// PURPOSE
//  Parametrised, registered address-to-one-hot write-enable decoder for the CPU54 register file.
//  Decodes an ADDR_W-bit register index into a 2**ADDR_W-wide enable vector, with selectable output polarity.
//  Uses a valid/ready handshake and a 2-entry skid buffer, so it sits between the WB stage and the regfile.
//  Produces no X or Z outputs; an enable-low transaction yields an all-inactive vector.
//  Forces register 0 ($zero) writes inactive and flags back-to-back writes to the same register.
// PARAMETERS
//  ADDR_W     5  width of the register index; output width is OUT_W = 2**ADDR_W
//  ACTIVE_LOW 1  1: selected bit is 0, others 1; 0: selected bit is 1, others 0
//  MASK_ZERO  1  1: index 0 decodes to all-inactive (MIPS $zero); 0: index 0 decodes normally
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       upstream word valid
//  in_ready   out  1       block can accept a word this cycle
//  in_addr    in   ADDR_W  register index to decode
//  in_ena     in   1       write enable; 0 -> decoded vector all inactive
//  out_valid  out  1       out_wen / out_same hold a valid word
//  out_ready  in   1       downstream consumes the word this cycle
//  out_wen    out  OUT_W   decoded enable vector
//  out_same   out  1       word is active and targets the same index as the previous delivered active word
// BEHAVIOUR
//  Transfers
//  - An input transfer occurs when in_valid && in_ready.
//  - An output transfer occurs when out_valid && out_ready.
//  Decode
//  - INACT = ACTIVE_LOW ? all-ones : all-zeros.
//  - Word is active iff in_ena && !(MASK_ZERO && in_addr == 0).
//  - Active word: INACT with bit in_addr inverted. Inactive word: INACT.
//  - Decode is computed at input and stored; no combinational path from in_* to out_*.
//  Storage: main register M and skid register S, each holding {wen, addr, active}.
//  - in_ready = !S.valid, driven directly from a flop. out_valid = M.valid. out_wen = M.valid ? M.wen : INACT.
//  - In transfer, M empty or M draining: word goes to M. Out transfer, S valid: S moves to M.
//  - In transfer while M valid and not draining: word goes to S. Only possible when S is empty.
//  - Simultaneous in and out transfers with S empty: M takes the new word; throughput is 1 word/cycle.
//  - Latency: 1 cycle from input transfer to out_valid when M is empty or draining.
//  - Ordering is strictly FIFO. No word is dropped or duplicated.
//  - While out_valid && !out_ready, out_wen and out_same hold stable.
//  out_same
//  - History register H = {addr, hvalid} updates on every output transfer of an active word.
//  - out_same = M.valid && M.active && H.hvalid && M.addr == H.addr.
//  - Inactive words never assert out_same and never update H.
//  Reset (rst_n low, async; effective immediately)
//  - M.valid = S.valid = H.hvalid = 0, giving out_valid = 0, out_same = 0, out_wen = INACT, in_ready = 1.
//  - Words held in M or S are discarded.
//  - Reset asserted mid-stream must not cause a partial or glitching enable on release.
//  Boundaries
//  - Full (M and S valid): in_ready = 0. Stays 0 until the cycle after the first out transfer.
//  - Empty with out_ready = 1: out_valid = 0 and out_wen = INACT; the regfile sees no writes.
//  - Index OUT_W-1: the MSB is selected, with no wrap.
//  - Index 0 with MASK_ZERO = 1: the word is delivered with all bits inactive and counts as a transfer.
// TESTING
//  1 Reset: rst_n = 0 mid-burst -> out_valid = 0, in_ready = 1, out_wen = 32'hFFFFFFFF (defaults).
//  2 Stream: out_ready = 1, addrs 1, 2, 31 with ena = 1 -> next cycles show FFFFFFFD, FFFFFFFB, 7FFFFFFF.
//    Throughput is 1 word/cycle.
//  3 $zero and ena = 0: addr 0 ena = 1 -> FFFFFFFF, out_same = 0.
//    addr 5 ena = 0 -> FFFFFFFF. With MASK_ZERO = 0, addr 0 -> FFFFFFFE.
//  4 Backpressure: out_ready = 0, send addrs 3, 4 -> in_ready = 0 after the second word, out_wen holds FFFFFFF7.
//    Release -> 3 then 4 delivered in order; in_ready returns to 1.
//  5 out_same: addrs 7, 7, 0, 7 (all ena = 1) -> out_same = 0, 1, 0, 1.
//    The masked 0 does not break the history.
//  6 ACTIVE_LOW = 0, ADDR_W = 3: addr 6 -> out_wen = 8'h40. Idle -> 8'h00.

Source files
------------

// File: rtl/wen_decoder_pipe.sv
// wen_decoder_pipe
// Registered address-to-one-hot write-enable decoder for the CPU54 register
// file. Sits between the WB stage and the regfile behind a valid/ready
// handshake with a 2-entry skid buffer (main register M plus skid register S).
// Also flags back-to-back active writes to the same register index.
//
// Parameters
//   ADDR_W     register index width; output width is OUT_W = 2**ADDR_W
//   ACTIVE_LOW 1: selected bit is 0, all others 1; 0: selected bit is 1
//   MASK_ZERO  1: index 0 ($zero) decodes to an all-inactive vector
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word this cycle (straight from a flop)
//   in_addr    register index to decode
//   in_ena     write enable; 0 gives an all-inactive vector
//   out_valid  out_wen / out_same hold a valid word
//   out_ready  downstream consumes the word this cycle
//   out_wen    decoded enable vector (inactive whenever out_valid is low)
//   out_same   active word targets the same index as the last delivered
//              active word
module wen_decoder_pipe #(
  parameter int ADDR_W     = 5,
  parameter int ACTIVE_LOW = 1,
  parameter int MASK_ZERO  = 1,
  localparam int OUT_W     = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_ena,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_wen,
  output logic              out_same
);

  localparam logic [OUT_W-1:0] INACT = {OUT_W{(ACTIVE_LOW != 0)}};
  localparam logic [OUT_W-1:0] ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

  logic              mValid, mActive, sValid, sActive, hValid, readyReg;
  logic [OUT_W-1:0]  mWen, sWen;
  logic [ADDR_W-1:0] mAddr, sAddr, hAddr;

  logic              mValidN, mActiveN, sValidN, sActiveN, hValidN;
  logic [OUT_W-1:0]  mWenN, sWenN;
  logic [ADDR_W-1:0] mAddrN, sAddrN, hAddrN;

  logic              inFire, outFire, newActive;
  logic [OUT_W-1:0]  newWen;

  // Decode happens on the way in, so the outputs only ever come from flops.
  always_comb begin
    newActive = in_ena && !((MASK_ZERO != 0) && (in_addr == '0));
    newWen    = newActive ? (INACT ^ (ONE << in_addr)) : INACT;
  end

  assign inFire  = in_valid && readyReg;
  assign outFire = mValid && out_ready;

  // Next-state for the M/S pair and the same-index history. S only ever
  // fills while M is stalled, and it refills M on the next output transfer,
  // which keeps the order strictly FIFO.
  always_comb begin
    mValidN  = mValid;
    mActiveN = mActive;
    mWenN    = mWen;
    mAddrN   = mAddr;
    sValidN  = sValid;
    sActiveN = sActive;
    sWenN    = sWen;
    sAddrN   = sAddr;
    hValidN  = hValid;
    hAddrN   = hAddr;

    if (outFire) begin
      if (mActive) begin
        hValidN = 1'b1;
        hAddrN  = mAddr;
      end
      if (sValid) begin
        mValidN  = 1'b1;
        mActiveN = sActive;
        mWenN    = sWen;
        mAddrN   = sAddr;
        sValidN  = 1'b0;
      end else if (inFire) begin
        mValidN  = 1'b1;
        mActiveN = newActive;
        mWenN    = newWen;
        mAddrN   = in_addr;
      end else begin
        mValidN  = 1'b0;
      end
    end else if (inFire) begin
      if (!mValid) begin
        mValidN  = 1'b1;
        mActiveN = newActive;
        mWenN    = newWen;
        mAddrN   = in_addr;
      end else begin
        sValidN  = 1'b1;
        sActiveN = newActive;
        sWenN    = newWen;
        sAddrN   = in_addr;
      end
    end
  end

  // State registers. in_ready gets its own flop, loaded with the inverse of
  // the next skid-valid, so upstream sees a clean registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid   <= 1'b0;
      mActive  <= 1'b0;
      mWen     <= INACT;
      mAddr    <= '0;
      sValid   <= 1'b0;
      sActive  <= 1'b0;
      sWen     <= INACT;
      sAddr    <= '0;
      hValid   <= 1'b0;
      hAddr    <= '0;
      readyReg <= 1'b1;
    end else begin
      mValid   <= mValidN;
      mActive  <= mActiveN;
      mWen     <= mWenN;
      mAddr    <= mAddrN;
      sValid   <= sValidN;
      sActive  <= sActiveN;
      sWen     <= sWenN;
      sAddr    <= sAddrN;
      hValid   <= hValidN;
      hAddr    <= hAddrN;
      readyReg <= !sValidN;
    end
  end

  assign in_ready  = readyReg;
  assign out_valid = mValid;
  assign out_wen   = mValid ? mWen : INACT;
  assign out_same  = mValid && mActive && hValid && (mAddr == hAddr);

endmodule
